// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage with an on-chip program store, loaded through a write port.
// Delivers one registered instruction per unstalled cycle, with jump flush, halt word and retire count.
module ins_fetch_unit #(
  parameter int                 INS_W     = 21,
  parameter int                 ADDR_W    = 8,
  parameter int                 DEPTH     = 256,
  parameter logic [INS_W-1:0]   HALT_WORD = {INS_W{1'b1}},
  parameter int                 CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LD_EN,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [INS_W-1:0]  LD_DATA,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic              STALL,
  input  logic              JMP_TAKEN,
  input  logic [ADDR_W-1:0] JMP_ADDR,
  output logic [INS_W-1:0]  INS,
  output logic              INS_VALID,
  output logic [ADDR_W-1:0] INS_ADDR,
  output logic [ADDR_W-1:0] PC,
  output logic              HALTED,
  output logic              BUSY,
  output logic [CNT_W-1:0]  RETIRED
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_L   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [INS_W-1:0]  mem_r [0:DEPTH-1];
  state_t            state_r, next_state_s;
  logic [ADDR_W-1:0] pc_r, pc_next_s;
  logic [INS_W-1:0]  ins_r, ins_next_s;
  logic              ins_valid_r, ins_valid_next_s;
  logic [ADDR_W-1:0] ins_addr_r, ins_addr_next_s;
  logic [CNT_W-1:0]  retired_r, retired_next_s;
  logic              mem_we_s;
  logic              ld_in_range_s;
  logic [INS_W-1:0]  fetch_word_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [CNT_W-1:0]  retired_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) sat_inc = v;
    else              sat_inc = v + CNT_ONE;
  endfunction

  // Addresses beyond the store read as the halt word so a stray PC stops the unit
  assign ld_in_range_s = ({1'b0, LD_ADDR} < DEPTH_L);
  assign fetch_word_s  = ({1'b0, pc_r} < DEPTH_L) ? mem_r[pc_r] : HALT_WORD;
  assign pc_inc_s      = ({1'b0, pc_r} == LAST_L) ? ADDR_ZERO : pc_r + ADDR_ONE;
  assign retired_inc_s = ins_valid_r ? sat_inc(retired_r) : retired_r;

  // Next-state and datapath next values; every path starts from "hold"
  always_comb begin
    next_state_s     = state_r;
    pc_next_s        = pc_r;
    ins_next_s       = ins_r;
    ins_valid_next_s = ins_valid_r;
    ins_addr_next_s  = ins_addr_r;
    retired_next_s   = retired_r;
    mem_we_s         = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        mem_we_s = LD_EN && ld_in_range_s;
        if (START) begin
          next_state_s     = ST_FETCH;
          pc_next_s        = START_ADDR;
          ins_valid_next_s = 1'b0;
          retired_next_s   = CNT_ZERO;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_FETCH: begin
        if (STALL) begin
          next_state_s = ST_FETCH;
        end else if (JMP_TAKEN && ins_valid_r) begin
          pc_next_s        = JMP_ADDR;
          ins_valid_next_s = 1'b0;
          retired_next_s   = retired_inc_s;
        end else if (fetch_word_s == HALT_WORD) begin
          next_state_s     = ST_HALTED;
          ins_valid_next_s = 1'b0;
          retired_next_s   = retired_inc_s;
        end else begin
          ins_next_s       = fetch_word_s;
          ins_addr_next_s  = pc_r;
          ins_valid_next_s = 1'b1;
          pc_next_s        = pc_inc_s;
          retired_next_s   = retired_inc_s;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      pc_r        <= ADDR_ZERO;
      ins_r       <= {INS_W{1'b0}};
      ins_valid_r <= 1'b0;
      ins_addr_r  <= ADDR_ZERO;
      retired_r   <= CNT_ZERO;
    end else begin
      state_r     <= next_state_s;
      pc_r        <= pc_next_s;
      ins_r       <= ins_next_s;
      ins_valid_r <= ins_valid_next_s;
      ins_addr_r  <= ins_addr_next_s;
      retired_r   <= retired_next_s;
    end
  end

  // Program store write port; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (!RST && mem_we_s) begin
      mem_r[LD_ADDR] <= LD_DATA;
    end
  end

  assign INS       = ins_r;
  assign INS_VALID = ins_valid_r;
  assign INS_ADDR  = ins_addr_r;
  assign PC        = pc_r;
  assign RETIRED   = retired_r;
  assign HALTED    = (state_r == ST_HALTED);
  assign BUSY      = (state_r == ST_FETCH);

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Directed bench for ins_fetch_unit: load/run, stall, jump flush, wrap, priority, load gating, reset.
module tb_ins_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LD_EN = 1'b0;
  logic [7:0]  LD_ADDR = 8'd0;
  logic [20:0] LD_DATA = 21'd0;
  logic        START = 1'b0;
  logic [7:0]  START_ADDR = 8'd0;
  logic        STALL = 1'b0;
  logic        JMP_TAKEN = 1'b0;
  logic [7:0]  JMP_ADDR = 8'd0;
  logic [20:0] INS;
  logic        INS_VALID;
  logic [7:0]  INS_ADDR;
  logic [7:0]  PC;
  logic        HALTED;
  logic        BUSY;
  logic [15:0] RETIRED;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [20:0] HW = 21'h1FFFFF;

  ins_fetch_unit dut (
    .CLK(CLK), .RST(RST), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .START(START), .START_ADDR(START_ADDR), .STALL(STALL), .JMP_TAKEN(JMP_TAKEN),
    .JMP_ADDR(JMP_ADDR), .INS(INS), .INS_VALID(INS_VALID), .INS_ADDR(INS_ADDR),
    .PC(PC), .HALTED(HALTED), .BUSY(BUSY), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [7:0] a, input logic [20:0] d);
    LD_EN = 1'b1; LD_ADDR = a; LD_DATA = d;
    step();
    LD_EN = 1'b0;
  endtask

  task automatic go(input logic [7:0] a);
    START = 1'b1; START_ADDR = a;
    step();
    START = 1'b0;
  endtask

  // Checks a valid instruction on the output along with PC and retire count
  task automatic chk_ins(input string tag, input logic [20:0] ins, input logic [7:0] addr,
                         input logic [7:0] pc, input logic [15:0] ret);
    chk({tag, "_ins"}, 32'(INS), 32'(ins));
    chk({tag, "_valid"}, 32'(INS_VALID), 32'd1);
    chk({tag, "_addr"}, 32'(INS_ADDR), 32'(addr));
    chk({tag, "_pc"}, 32'(PC), 32'(pc));
    chk({tag, "_ret"}, 32'(RETIRED), 32'(ret));
  endtask

  task automatic chk_halt(input string tag, input logic [7:0] pc, input logic [15:0] ret);
    chk({tag, "_halted"}, 32'(HALTED), 32'd1);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_valid"}, 32'(INS_VALID), 32'd0);
    chk({tag, "_pc"}, 32'(PC), 32'(pc));
    chk({tag, "_ret"}, 32'(RETIRED), 32'(ret));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ins"}, 32'(INS), 32'd0);
    chk({tag, "_valid"}, 32'(INS_VALID), 32'd0);
    chk({tag, "_addr"}, 32'(INS_ADDR), 32'd0);
    chk({tag, "_pc"}, 32'(PC), 32'd0);
    chk({tag, "_halted"}, 32'(HALTED), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_ret"}, 32'(RETIRED), 32'd0);
  endtask

  initial begin
    // Reset state
    step(); step();
    RST = 1'b0;
    chk_reset("rst");

    // Load and run
    ld(8'd0, 21'h0B005); ld(8'd1, 21'h0B107); ld(8'd2, 21'h18020); ld(8'd3, HW);
    go(8'd0);
    chk("run_busy", 32'(BUSY), 32'd1);
    chk("run_bubble", 32'(INS_VALID), 32'd0);
    step(); chk_ins("run0", 21'h0B005, 8'd0, 8'd1, 16'd0);
    step(); chk_ins("run1", 21'h0B107, 8'd1, 8'd2, 16'd1);
    step(); chk_ins("run2", 21'h18020, 8'd2, 8'd3, 16'd2);
    step(); chk_halt("run_h", 8'd3, 16'd3);

    // Stall while 0x0B107 is on INS
    go(8'd0);
    step(); chk_ins("st0", 21'h0B005, 8'd0, 8'd1, 16'd0);
    step(); chk_ins("st1", 21'h0B107, 8'd1, 8'd2, 16'd1);
    STALL = 1'b1; JMP_TAKEN = 1'b1; JMP_ADDR = 8'd64;
    for (int i = 0; i < 3; i++) begin
      step(); chk_ins("stall", 21'h0B107, 8'd1, 8'd2, 16'd1);
    end
    STALL = 1'b0; JMP_TAKEN = 1'b0;
    step(); chk_ins("st2", 21'h18020, 8'd2, 8'd3, 16'd2);
    step(); chk_halt("st_h", 8'd3, 16'd3);

    // Jump flush
    ld(8'd0, 21'h00A0A); ld(8'd1, 21'h00B0B); ld(8'd2, 21'h00C0C);
    ld(8'd64, 21'h00D0D); ld(8'd65, HW);
    go(8'd0);
    step(); chk_ins("jA", 21'h00A0A, 8'd0, 8'd1, 16'd0);
    JMP_TAKEN = 1'b1; JMP_ADDR = 8'd64;
    step(); JMP_TAKEN = 1'b0;
    chk("j_bubble", 32'(INS_VALID), 32'd0);
    chk("j_pc", 32'(PC), 32'd64);
    chk("j_ret", 32'(RETIRED), 32'd1);
    chk("j_busy", 32'(BUSY), 32'd1);
    step(); chk_ins("jD", 21'h00D0D, 8'd64, 8'd65, 16'd1);
    step(); chk_halt("j_h", 8'd65, 16'd2);

    // Wrap from DEPTH-1 to 0
    ld(8'd254, 21'h11111); ld(8'd255, 21'h12222); ld(8'd0, HW);
    go(8'd254);
    step(); chk_ins("wX", 21'h11111, 8'd254, 8'd255, 16'd0);
    step(); chk_ins("wY", 21'h12222, 8'd255, 8'd0, 16'd1);
    step(); chk_halt("w_h", 8'd0, 16'd2);

    // Jump beats halt; load during FETCH is dropped
    ld(8'd10, 21'h01010); ld(8'd11, HW); ld(8'd20, 21'h02020); ld(8'd21, HW);
    go(8'd10);
    step(); chk_ins("pE", 21'h01010, 8'd10, 8'd11, 16'd0);
    JMP_TAKEN = 1'b1; JMP_ADDR = 8'd20;
    LD_EN = 1'b1; LD_ADDR = 8'd21; LD_DATA = 21'h05555;
    step(); JMP_TAKEN = 1'b0; LD_EN = 1'b0;
    chk("p_busy", 32'(BUSY), 32'd1);
    chk("p_halted", 32'(HALTED), 32'd0);
    chk("p_pc", 32'(PC), 32'd20);
    step(); chk_ins("pF", 21'h02020, 8'd20, 8'd21, 16'd1);
    step(); chk_halt("p_h", 8'd21, 16'd2);
    go(8'd21);
    step(); chk_halt("gate_rb", 8'd21, 16'd0);

    // Jump with nothing valid on INS is ignored
    go(8'd20);
    JMP_TAKEN = 1'b1; JMP_ADDR = 8'd10;
    step(); JMP_TAKEN = 1'b0;
    chk_ins("jinv", 21'h02020, 8'd20, 8'd21, 16'd0);
    step(); chk_halt("jinv_h", 8'd21, 16'd1);

    // Reset mid-run with RETIRED=5, write presented with reset is dropped
    for (int i = 0; i < 8; i++) ld(8'(30 + i), 21'(21'h03000 + i));
    ld(8'd38, HW);
    go(8'd30);
    for (int i = 0; i < 6; i++) step();
    chk_ins("pre_rst", 21'h03005, 8'd35, 8'd36, 16'd5);
    RST = 1'b1; LD_EN = 1'b1; LD_ADDR = 8'd30; LD_DATA = 21'h00000;
    step(); RST = 1'b0; LD_EN = 1'b0;
    chk_reset("mid_rst");
    go(8'd30);
    step(); chk_ins("rerun", 21'h03000, 8'd30, 8'd31, 16'd0);

    // Write and START together from IDLE: write lands before the first fetch
    RST = 1'b1; step(); RST = 1'b0;
    ld(8'd41, HW);
    LD_EN = 1'b1; LD_ADDR = 8'd40; LD_DATA = 21'h03030;
    go(8'd40);
    LD_EN = 1'b0;
    step(); chk_ins("ldst", 21'h03030, 8'd40, 8'd41, 16'd0);
    step(); chk_halt("ldst_h", 8'd41, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
